// File: rtl/b2bcd_pkg.sv
// Shared types and constants for the BCD seven-segment scheduler, its engine
// and the bench.
package b2bcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RESP,
    S_GAP
  } sched_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // segment order is abcdefg, msb = a
  localparam logic [6:0] NUM_0 = 7'b1111110;
  localparam logic [6:0] NUM_1 = 7'b0110000;
  localparam logic [6:0] NUM_2 = 7'b1101101;
  localparam logic [6:0] NUM_3 = 7'b1111001;
  localparam logic [6:0] NUM_4 = 7'b0110011;
  localparam logic [6:0] NUM_5 = 7'b1011011;
  localparam logic [6:0] NUM_6 = 7'b1011111;
  localparam logic [6:0] NUM_7 = 7'b1110000;
  localparam logic [6:0] NUM_8 = 7'b1111111;
  localparam logic [6:0] NUM_9 = 7'b1111011;

  function automatic logic has_bad_digit(input logic [15:0] word);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (word[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/b2bcd_sched_rr_pick.sv
// Round-robin pick: first set request at or above rr_ptr, else lowest set one.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic             any,
  output logic [IDW-1:0]   grant_id
);

  always_comb begin
    any      = 1'b0;
    grant_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && (i >= int'(rr_ptr)) && req[i]) begin
        any      = 1'b1;
        grant_id = IDW'(i);
      end
    end
    // wrap-around pass: only reached when nothing at or above the pointer
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i]) begin
        any      = 1'b1;
        grant_id = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/b2bcd_sched.sv
// Shares one BCD seven-segment engine among N_REQ requesters: validate, grant,
// stream four digits, wait for the result (with timeout) and return it tagged.
//   state  | meaning
//   S_IDLE | waiting for any req; grant sampled here
//   S_LOAD | streaming digits 0..3 into the engine
//   S_WAIT | waiting for eng_out_valid, timer running
//   S_RESP | rsp_valid cycle
//   S_GAP  | forced idle before the next grant
module b2bcd_sched
  import b2bcd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int GAP     = 2,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      ack,
  output logic                  busy,
  output logic                  eng_in_valid,
  output logic [3:0]            eng_in_data,
  input  logic                  eng_out_valid,
  input  logic [6:0]            eng_seg_100,
  input  logic [6:0]            eng_seg_10,
  input  logic [6:0]            eng_seg_1,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic [6:0]            rsp_seg_100,
  output logic [6:0]            rsp_seg_10,
  output logic [6:0]            rsp_seg_1
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  sched_state_t     state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [15:0]      word_q, word_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             in_valid_q, in_valid_d;
  logic [3:0]       in_data_q, in_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;
  logic [6:0]       seg_100_q, seg_100_d, seg_10_q, seg_10_d, seg_1_q, seg_1_d;

  logic             any;
  logic [IDW-1:0]   grant_id;
  logic [15:0]      sel_word;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .any      (any),
    .grant_id (grant_id)
  );

  assign sel_word = req_data[{grant_id, 4'b0000} +: 16];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    ack_d       = '0;
    in_valid_d  = 1'b0;
    in_data_d   = 4'd0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    seg_100_d   = seg_100_q;
    seg_10_d    = seg_10_q;
    seg_1_d     = seg_1_q;

    case (state_q)
      S_IDLE: begin
        if (any) begin
          ack_d    = N_REQ'(1) << grant_id;
          id_d     = grant_id;
          word_d   = sel_word;
          rr_ptr_d = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
          if (has_bad_digit(sel_word)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_id;
            rsp_err_d   = 1'b1;
            seg_100_d   = SEG_BLANK;
            seg_10_d    = SEG_BLANK;
            seg_1_d     = SEG_BLANK;
          end else begin
            state_d    = S_LOAD;
            cnt_d      = 2'd0;
            in_valid_d = 1'b1;
            in_data_d  = sel_word[3:0];
          end
        end
      end
      S_LOAD: begin
        if (cnt_q == 2'd3) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          in_valid_d = 1'b1;
          in_data_d  = word_q[{cnt_d, 2'b00} +: 4];
        end
      end
      S_WAIT: begin
        // a result on the expiry edge still wins over the timeout
        if (eng_out_valid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b0;
          seg_100_d   = eng_seg_100;
          seg_10_d    = eng_seg_10;
          seg_1_d     = eng_seg_1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b1;
          seg_100_d   = SEG_BLANK;
          seg_10_d    = SEG_BLANK;
          seg_1_d     = SEG_BLANK;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        state_d = S_GAP;
        gap_d   = '0;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
        else                       gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      seg_100_q   <= '0;
      seg_10_q    <= '0;
      seg_1_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      seg_100_q   <= seg_100_d;
      seg_10_q    <= seg_10_d;
      seg_1_q     <= seg_1_d;
    end
  end

  assign ack          = ack_q;
  assign busy         = busy_q;
  assign eng_in_valid = in_valid_q;
  assign eng_in_data  = in_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_seg_100  = seg_100_q;
  assign rsp_seg_10   = seg_10_q;
  assign rsp_seg_1    = seg_1_q;

endmodule

// File: tb/tb_b2bcd_sched.sv
// Directed bench for b2bcd_sched: engine stand-in with programmable latency,
// event logs sampled on the falling edge, hand-computed expectations.
module tb_b2bcd_sched;
  import b2bcd_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  ack;
  logic        busy, eng_in_valid, rsp_valid, rsp_err;
  logic [3:0]  eng_in_data;
  logic        eng_out_valid = 1'b0;
  logic [6:0]  eng_seg_100 = '0, eng_seg_10 = '0, eng_seg_1 = '0;
  logic [1:0]  rsp_id;
  logic [6:0]  rsp_seg_100, rsp_seg_10, rsp_seg_1;

  b2bcd_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .busy(busy),
    .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data), .eng_out_valid(eng_out_valid),
    .eng_seg_100(eng_seg_100), .eng_seg_10(eng_seg_10), .eng_seg_1(eng_seg_1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_seg_100(rsp_seg_100), .rsp_seg_10(rsp_seg_10), .rsp_seg_1(rsp_seg_1)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int cyc; } ack_t;
  typedef struct { int id; int err; logic [20:0] segs; int cyc; } rsp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_inv_cyc = 0;
  int          eng_delay = 5;
  ack_t        ack_log[$];
  rsp_t        rsp_log[$];
  logic [3:0]  din_log[$];
  int          burst_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    ack_log.delete();
    rsp_log.delete();
    din_log.delete();
    burst_log.delete();
  endtask

  task automatic wait_ack(input string tag, output logic [3:0] a);
    int k;
    k = 0;
    a = '0;
    while (k < 300) begin
      @(negedge clk);
      if (|ack) begin
        a = ack;
        break;
      end
      k++;
    end
    chk(tag, 32'(|a), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input int n);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(rsp_log.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
  endtask

  // event monitor
  initial begin
    logic prev_inv;
    prev_inv = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (ack[i]) ack_log.push_back('{id: i, cyc: cyc});
      end
      if (eng_in_valid) begin
        din_log.push_back(eng_in_data);
        if (!prev_inv) burst_log.push_back(cyc);
        last_inv_cyc = cyc;
      end
      if (rsp_valid) begin
        rsp_log.push_back('{id: int'(rsp_id), err: int'(rsp_err),
                            segs: {rsp_seg_100, rsp_seg_10, rsp_seg_1}, cyc: cyc});
      end
      prev_inv = eng_in_valid;
      cyc++;
    end
  end

  // engine stand-in: pulses out_valid eng_delay cycles after the last digit (<0 = silent)
  initial begin
    int cnt;
    logic pending;
    cnt = 0;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      eng_out_valid = 1'b0;
      if (eng_in_valid) begin
        pending = 1'b1;
        cnt = 0;
      end else if (pending) begin
        cnt++;
        if (cnt == eng_delay) begin
          eng_out_valid = 1'b1;
          pending = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  a;
    logic [15:0] packed_d;

    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({ack, busy, eng_in_valid, eng_in_data, rsp_valid, rsp_id, rsp_err}), 32'd0);
    chk("rst_segs", 32'({rsp_seg_100, rsp_seg_10, rsp_seg_1}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single valid request
    clear_logs();
    eng_delay = 5;
    eng_seg_100 = NUM_0; eng_seg_10 = NUM_4; eng_seg_1 = NUM_2;
    req_data[31:16] = 16'h4321;
    req = 4'b0010;
    wait_ack("t1_ack_seen", a);
    req = '0;
    wait_rsp("t1_rsp_seen", 1);
    wait_idle();
    chk("t1_ack_count", 32'(ack_log.size()), 32'd1);
    chk("t1_ack_id", 32'(ack_log[0].id), 32'd1);
    chk("t1_ack_with_d0", 32'(ack_log[0].cyc), 32'(burst_log[0]));
    packed_d = '0;
    for (int i = 0; i < din_log.size() && i < 4; i++) packed_d[4*i +: 4] = din_log[i];
    chk("t1_digit_count", 32'(din_log.size()), 32'd4);
    chk("t1_digits", 32'(packed_d), 32'h4321);
    chk("t1_rsp_id", 32'(rsp_log[0].id), 32'd1);
    chk("t1_rsp_err", 32'(rsp_log[0].err), 32'd0);
    chk("t1_segs", 32'(rsp_log[0].segs), 32'({NUM_0, NUM_4, NUM_2}));
    chk("t1_latency", 32'(rsp_log[0].cyc - last_inv_cyc), 32'd6);

    // all four requesting right after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    req_data = {16'h1234, 16'h0123, 16'h0012, 16'h0001};
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_ack("t2_ack_seen", a);
      req = req & ~a;
    end
    wait_rsp("t2_rsp_seen", 4);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_ack_order%0d", i), 32'(ack_log[i].id), 32'(i));
      chk($sformatf("t2_rsp_id%0d", i), 32'(rsp_log[i].id), 32'(i));
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_spacing%0d", i), 32'(burst_log[i+1] - rsp_log[i].cyc), 32'(GAP + 2));
    end
    chk("t2_digit_count", 32'(din_log.size()), 32'd16);

    // invalid digit: immediate error, no engine traffic
    clear_logs();
    req_data[47:32] = 16'h12A3;
    req = 4'b0100;
    wait_ack("t3_ack_seen", a);
    req = '0;
    wait_rsp("t3_rsp_seen", 1);
    wait_idle();
    chk("t3_ack_id", 32'(ack_log[0].id), 32'd2);
    chk("t3_same_cycle", 32'(rsp_log[0].cyc), 32'(ack_log[0].cyc));
    chk("t3_rsp_id", 32'(rsp_log[0].id), 32'd2);
    chk("t3_rsp_err", 32'(rsp_log[0].err), 32'd1);
    chk("t3_segs", 32'(rsp_log[0].segs), 32'd0);
    chk("t3_no_engine", 32'(din_log.size()), 32'd0);

    // silent engine: timeout error
    clear_logs();
    eng_delay = -1;
    eng_seg_100 = NUM_8; eng_seg_10 = NUM_8; eng_seg_1 = NUM_8;
    req_data[15:0] = 16'h9876;
    req = 4'b0001;
    wait_ack("t4_ack_seen", a);
    req = '0;
    wait_rsp("t4_rsp_seen", 1);
    wait_idle();
    chk("t4_rsp_id", 32'(rsp_log[0].id), 32'd0);
    chk("t4_rsp_err", 32'(rsp_log[0].err), 32'd1);
    chk("t4_segs", 32'(rsp_log[0].segs), 32'd0);
    chk("t4_timeout_lat", 32'(rsp_log[0].cyc - last_inv_cyc), 32'(TIMEOUT + 1));

    // served normally after a timeout
    clear_logs();
    eng_delay = 5;
    eng_seg_100 = NUM_5; eng_seg_10 = NUM_6; eng_seg_1 = NUM_3;
    req_data[31:16] = 16'h0505;
    req = 4'b0010;
    wait_ack("t4b_ack_seen", a);
    req = '0;
    wait_rsp("t4b_rsp_seen", 1);
    wait_idle();
    chk("t4b_rsp_id", 32'(rsp_log[0].id), 32'd1);
    chk("t4b_rsp_err", 32'(rsp_log[0].err), 32'd0);
    chk("t4b_segs", 32'(rsp_log[0].segs), 32'({NUM_5, NUM_6, NUM_3}));

    // result arriving on the expiry edge
    clear_logs();
    eng_delay = TIMEOUT;
    eng_seg_100 = NUM_1; eng_seg_10 = NUM_7; eng_seg_1 = NUM_9;
    req_data[63:48] = 16'h2468;
    req = 4'b1000;
    wait_ack("t5_ack_seen", a);
    req = '0;
    wait_rsp("t5_rsp_seen", 1);
    wait_idle();
    chk("t5_rsp_id", 32'(rsp_log[0].id), 32'd3);
    chk("t5_rsp_err", 32'(rsp_log[0].err), 32'd0);
    chk("t5_segs", 32'(rsp_log[0].segs), 32'({NUM_1, NUM_7, NUM_9}));
    chk("t5_lat", 32'(rsp_log[0].cyc - last_inv_cyc), 32'(TIMEOUT + 1));

    // reset during digit 2 of a burst
    clear_logs();
    eng_delay = 5;
    req_data[31:16] = 16'h4321;
    req = 4'b0010;
    begin
      int k;
      k = 0;
      while (!(eng_in_valid && eng_in_data == 4'd3) && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("t6_reached_d2", 32'(k < 100), 32'd1);
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("t6_outputs", 32'({ack, busy, eng_in_valid, eng_in_data, rsp_valid, rsp_id, rsp_err}), 32'd0);
    chk("t6_segs", 32'({rsp_seg_100, rsp_seg_10, rsp_seg_1}), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_rsp", 32'(rsp_log.size()), 32'd0);
    clear_logs();
    req_data[15:0] = 16'h0001;
    req = 4'b1001;
    wait_ack("t6_ack_seen", a);
    req = '0;
    chk("t6_grant_from0", 32'(a), 32'b0001);
    wait_rsp("t6_rsp_seen", 1);
    wait_idle();
    chk("t6_rsp_id", 32'(rsp_log[0].id), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
